// File: rtl/ccff_chain_loader_if.sv
// Word-stream handshake between a bitstream source (master) and ccff_chain_loader (slave).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words onto a configuration chain head, MSB first, counting CHAIN_LEN bits.
// Optional readback compare against ccff_tail is enabled by defining CCFF_VERIFY_EN.
module ccff_chain_loader #(
  parameter int  CHAIN_LEN = 36,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               prog_clk,
  input  logic               prog_reset_n,
  input  logic               start,
  input  logic               abort,
  ccff_chain_loader_if.slave bus,
  output logic               ccff_head,
  output logic               ccff_shift_en,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done
`ifdef CCFF_VERIFY_EN
  ,
  input  logic               verify,
  output logic               mismatch,
  output logic [CNT_W-1:0]   mismatch_cnt
`endif
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] sreg, sreg_n;
  logic [CNT_W-1:0]  remaining, remaining_n;
  logic [WB_W-1:0]   wbits, wbits_n;
  logic              word_ready;
  logic              take;

  assign bus.word_ready = word_ready;
  assign take           = bus.word_valid && word_ready;

  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    remaining_n = remaining;
    wbits_n     = wbits;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n     = FETCH;
            remaining_n = CNT_W'(CHAIN_LEN);
          end
        end
        FETCH: begin
          if (take) begin
            sreg_n  = bus.word_in;
            // Final word may be partial: only its upper bits are shifted.
            wbits_n = (int'(remaining) < WORD_W) ? WB_W'(remaining) : WB_W'(WORD_W);
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          sreg_n      = sreg << 1;
          wbits_n     = wbits - 1'b1;
          remaining_n = remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_n = DONE;
          end else if (wbits == WB_W'(1)) begin
            state_n = FETCH;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they are glitch-free and
  // line up with the state they describe.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state         <= IDLE;
      sreg          <= '0;
      remaining     <= '0;
      wbits         <= '0;
      word_ready    <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      sreg          <= sreg_n;
      remaining     <= remaining_n;
      wbits         <= wbits_n;
      word_ready    <= (state_n == FETCH);
      ccff_shift_en <= (state_n == SHIFT);
      ccff_head     <= (state_n == SHIFT) && sreg_n[WORD_W-1];
      busy          <= (state_n != IDLE);
      done          <= (state_n == DONE);
    end
  end

`ifdef CCFF_VERIFY_EN
  logic cmp_mode;
  logic start_acc;

  assign start_acc = (state == IDLE) && start && !abort;

  // The tail bit seen during a shift is the old chain content for the bit now on the head.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      cmp_mode     <= 1'b0;
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else if (start_acc) begin
      cmp_mode     <= verify;
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else if (cmp_mode && (state == SHIFT) && (ccff_tail != ccff_head)) begin
      mismatch <= 1'b1;
      if (mismatch_cnt != '1) begin
        mismatch_cnt <= mismatch_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
